// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS core: Tuse/Tnew data stalls,
// HI/LO mult/div busy sequencer, and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic        D_md,
  input  logic [4:0]  E_A3,
  input  logic [1:0]  E_Tnew,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  M_Tnew,
  input  logic        E_md_start,
  input  logic        E_md_type,
  output logic        Stall,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_LAT - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;

  logic stall_rs;
  logic stall_rt;
  logic md_stall;

  // A Tuse of 3 marks an unused operand; $0 is hard-wired and never forwarded.
  assign stall_rs = (D_Tuse_rs != 2'd3) && (D_rs != 5'd0) &&
                    (((D_rs == E_A3) && (E_Tnew > D_Tuse_rs)) ||
                     ((D_rs == M_A3) && (M_Tnew > D_Tuse_rs)));

  assign stall_rt = (D_Tuse_rt != 2'd3) && (D_rt != 5'd0) &&
                    (((D_rt == E_A3) && (E_Tnew > D_Tuse_rt)) ||
                     ((D_rt == M_A3) && (M_Tnew > D_Tuse_rt)));

  assign md_stall = D_md && (md_busy || E_md_start);
  assign Stall    = stall_rs | stall_rt | md_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Starts seen while BUSY (including the done cycle) are dropped.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (E_md_start) begin
          state_nxt = BUSY;
          cnt_nxt   = E_md_type ? DIV_LOAD : MULT_LOAD;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    md_busy = (state == BUSY);
    md_done = (state == BUSY) && (cnt == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
    end else if (Stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: driver pushes model expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_hazard_stall_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs, D_rt, E_A3, M_A3;
  logic [1:0]  D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic        D_md, E_md_start, E_md_type;
  logic        Stall, md_busy, md_done;
  logic [31:0] stall_cnt;

  typedef struct {
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: remaining busy cycles and the stall tally.
  int          m_busy_left = 0;
  logic [31:0] m_cnt       = 32'd0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .D_md(D_md), .E_A3(E_A3), .E_Tnew(E_Tnew), .M_A3(M_A3), .M_Tnew(M_Tnew),
    .E_md_start(E_md_start), .E_md_type(E_md_type),
    .Stall(Stall), .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
  );

  function automatic logic reg_hazard(input logic [4:0] r, input logic [1:0] tuse);
    int t;
    t = int'(tuse);
    if (t == 3 || r == 5'd0) return 1'b0;
    return (r == E_A3 && int'(E_Tnew) > t) || (r == M_A3 && int'(M_Tnew) > t);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("Stall",     32'(Stall),   32'(e.stall));
      check("md_busy",   32'(md_busy), 32'(e.busy));
      check("md_done",   32'(md_done), 32'(e.done));
      check("stall_cnt", stall_cnt,    e.cnt);
    end
  end

  task automatic clear_inputs();
    D_rs = 0; D_rt = 0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3; D_md = 0;
    E_A3 = 0; E_Tnew = 0; M_A3 = 0; M_Tnew = 0; E_md_start = 0; E_md_type = 0;
  endtask

  // Inputs are already applied; record this cycle's expectation, then clock.
  task automatic cycle();
    exp_t e;
    e.busy  = (m_busy_left > 0);
    e.done  = (m_busy_left == 1);
    e.stall = reg_hazard(D_rs, D_Tuse_rs) || reg_hazard(D_rt, D_Tuse_rt) ||
              (D_md && (e.busy || E_md_start));
    e.cnt   = m_cnt;
    q.push_back(e);
    @(posedge clk);
    if (reset) begin
      m_busy_left = 0;
      m_cnt       = 32'd0;
    end else begin
      if (m_busy_left > 0)  m_busy_left = m_busy_left - 1;
      else if (E_md_start)  m_busy_left = E_md_type ? DIV_LAT : MULT_LAT;
      if (e.stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
    #1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cycle();                       // reset still high: counter stays 0
    reset = 1'b0;

    // Load-use on rs: E then M producer, then resolved.
    D_rs = 5'd1; D_Tuse_rs = 2'd0; E_A3 = 5'd1; E_Tnew = 2'd2;
    cycle();
    E_A3 = 5'd0; E_Tnew = 2'd0; M_A3 = 5'd1; M_Tnew = 2'd1;
    cycle();
    M_Tnew = 2'd0;
    cycle();

    // $0 and an unused operand never stall; rt path with Tuse=1.
    clear_inputs();
    E_A3 = 5'd0; E_Tnew = 2'd2; D_rs = 5'd0; D_Tuse_rs = 2'd0;
    cycle();
    E_A3 = 5'd7; D_rs = 5'd7; D_Tuse_rs = 2'd3;
    cycle();
    D_rt = 5'd7; D_Tuse_rt = 2'd1;
    cycle();
    D_Tuse_rt = 2'd2;
    cycle();

    // mult with D_md held across the whole busy window.
    clear_inputs();
    D_md = 1'b1; E_md_start = 1'b1; E_md_type = 1'b0;
    cycle();
    E_md_start = 1'b0;
    repeat (MULT_LAT + 2) cycle();

    // div with an illegal restart at busy cycle 3, and a start on the done cycle.
    clear_inputs();
    E_md_start = 1'b1; E_md_type = 1'b1;
    cycle();
    E_md_start = 1'b0;
    for (int i = 1; i <= DIV_LAT + 1; i++) begin
      E_md_start = (i == 3 || i == DIV_LAT);
      E_md_type  = (i == 3) ? 1'b0 : 1'b1;
      cycle();
    end
    clear_inputs();
    repeat (2) cycle();

    // Reset during busy cycle 4 of a div aborts without a done pulse.
    E_md_start = 1'b1; E_md_type = 1'b1; D_md = 1'b1;
    cycle();
    E_md_start = 1'b0;
    repeat (3) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (3) cycle();

    // Saturation: preload the counter just below all-ones.
    clear_inputs();
    force dut.stall_cnt = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    cycle();
    release dut.stall_cnt;
    D_rs = 5'd3; D_Tuse_rs = 2'd0; E_A3 = 5'd3; E_Tnew = 2'd1;
    repeat (4) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;

    // Randomized traffic with small register numbers for frequent matches.
    for (int n = 0; n < 1500; n++) begin
      D_rs       = 5'($urandom_range(0, 3));
      D_rt       = 5'($urandom_range(0, 3));
      D_Tuse_rs  = 2'($urandom_range(0, 3));
      D_Tuse_rt  = 2'($urandom_range(0, 3));
      E_A3       = 5'($urandom_range(0, 3));
      M_A3       = 5'($urandom_range(0, 3));
      E_Tnew     = 2'($urandom_range(0, 3));
      M_Tnew     = 2'($urandom_range(0, 3));
      D_md       = ($urandom_range(0, 3) == 0);
      E_md_start = ($urandom_range(0, 5) == 0);
      E_md_type  = 1'($urandom_range(0, 1));
      reset      = ($urandom_range(0, 63) == 0);
      cycle();
    end
    reset = 1'b0;
    clear_inputs();
    cycle();

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d entries expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete within bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS core.
- Decides each cycle whether the D stage freezes and the D/E register injects a bubble, using Tuse/Tnew register-dependency checks.
- Owns the multi-cycle mult/div busy sequencer (HI/LO unit), so HI/LO-consuming instructions in D wait until the unit is idle.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MULT_LAT, 5, cycles the mult/multu operation keeps the unit busy after start.
- DIV_LAT, 10, cycles the div/divu operation keeps the unit busy after start.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- D_rs  input  5  rs field of the instruction in D
- D_rt  input  5  rt field of the instruction in D
- D_Tuse_rs  input  2  cycles until D needs rs; 3 = not used
- D_Tuse_rt  input  2  cycles until D needs rt; 3 = not used
- D_md  input  1  instruction in D reads or writes HI/LO, or is mult/div
- E_A3  input  5  destination register of the instruction in E
- E_Tnew  input  2  cycles until E's result is available
- M_A3  input  5  destination register of the instruction in M
- M_Tnew  input  2  cycles until M's result is available
- E_md_start  input  1  instruction in E is mult/multu/div/divu; 1-cycle pulse
- E_md_type  input  1  0 = mult class, 1 = div class
- Stall  output  1  freeze PC and F/D; bubble the D/E register
- md_busy  output  1  HI/LO unit is executing
- md_done  output  1  1-cycle pulse on the last busy cycle
- stall_cnt  output  32  saturating count of cycles with Stall=1

Behaviour:
Data stall (combinational, same cycle):
- stall_rs = D_Tuse_rs != 3 && D_rs != 0 && ((D_rs == E_A3 && E_Tnew > D_Tuse_rs) || (D_rs == M_A3 && M_Tnew > D_Tuse_rs)).
- stall_rt is the same check with rt.
- $0 never causes a stall. Tnew/Tuse comparisons are unsigned 2-bit.

MD stall (combinational):
- md_stall = D_md && (md_busy || E_md_start).
- Stall = stall_rs | stall_rt | md_stall.

MD sequencer (registered), states IDLE and BUSY; internal 4-bit counter cnt:
- IDLE, E_md_start=1: go to BUSY; cnt <= (E_md_type ? DIV_LAT : MULT_LAT) - 1.
- BUSY, cnt != 0: cnt <= cnt - 1.
- BUSY, cnt == 0: go to IDLE; md_done = 1 this cycle (combinational from state and cnt).
- md_busy = (state == BUSY). Unit is busy for exactly MULT_LAT or DIV_LAT cycles, starting the cycle after the start pulse.
- E_md_start while BUSY is ignored: no restart, no counter change. It cannot occur legally because D_md stalls the instruction.
- Back-to-back: a start arriving in the cycle md_done=1 is also ignored (state is still BUSY). The stalled instruction issues after the unit returns to IDLE.

stall_cnt:
- Increments on every clock edge where Stall=1.
- Saturates at 32'hFFFFFFFF.

Reset:
- Synchronous. State IDLE, cnt=0, stall_cnt=0.
- After the reset edge: md_busy=0, md_done=0, and Stall depends only on inputs.
- Reset mid-operation aborts the sequencer immediately: the next cycle is IDLE and no md_done pulse is produced.

Initial values equal reset values.

Test Plan:
- lw $1 in E (E_A3=1, E_Tnew=2); D beq uses rs=1 with Tuse=0 -> Stall=1. Next cycle with M_A3=1, M_Tnew=1 -> Stall=1. Then M_Tnew=0 -> Stall=0. stall_cnt=2.
- E_A3=0, E_Tnew=2; D uses rs=0 with Tuse=0 -> Stall=0. D_Tuse_rs=3 with a matching rs -> Stall=0.
- E_md_start=1, E_md_type=0 at cycle t -> md_busy=1 for cycles t+1..t+5, md_done=1 only at t+5. D_md=1 held throughout -> Stall=1 at t..t+5 and 0 at t+6.
- div start (type=1) -> busy exactly 10 cycles. A second E_md_start at busy cycle 3 -> no change, done still at cycle 10.
- reset asserted during busy cycle 4 of a div -> next cycle md_busy=0, stall_cnt=0, no md_done pulse.
- Preload by holding Stall=1 for 2^32+3 cycles (or force stall_cnt to FFFFFFFE) -> saturates at FFFFFFFF, no wrap to 0.
